decode_regfile: RTL and testbench

- SEQ decode-side register file and read stage; the reader counterpart to the write-back stage.
- Holds the 15 Y86-64 program registers (%rax..%r14, IDs 0x0–0xE).
- Derives srcA/srcB from icode/rA/rB and returns registered valA/valB one cycle after a decode request.
- Accepts the write-back stage's dstE/dstM writes on the same clock, with write-to-read bypass so a read never returns stale data.

---
 rtl/decode_regfile.sv | 135 +++++++++++++
 tb/tb_decode_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// decode_regfile
//   Decode-side register file and read stage for a SEQ Y86-64 core.
//   Holds the program registers, picks srcA/srcB from icode/rA/rB, and
//   returns registered operands one cycle after a decode request. Write-back
//   results presented on the same edge are forwarded into the read so an
//   operand is never stale.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   decode request this cycle
//   stall      hold all outputs, ignore in_valid (writes still happen)
//   icode      instruction code
//   rA, rB     register fields
//   dstE/valE  write-back E port (dstE = 0xF means no write)
//   dstM/valM  write-back M port (dstM = 0xF means no write)
//   srcA/srcB  registered source IDs
//   valA/valB  registered operands
//   out_valid  outputs carry a fresh result
module decode_regfile #(
  parameter int         WIDTH  = 64,
  parameter int         NREG   = 15,
  parameter logic [3:0] RSP_ID = 4'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  output logic [3:0]       srcA,
  output logic [3:0]       srcB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             out_valid
);

  localparam logic [3:0] RNONE = 4'hF;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [3:0]       r_src_a;
  logic [3:0]       r_src_b;
  logic [WIDTH-1:0] r_val_a;
  logic [WIDTH-1:0] r_val_b;
  logic             r_out_valid;

  logic [3:0]       w_src_a;
  logic [3:0]       w_src_b;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_we_e;
  logic             w_we_m;
  logic             w_read;

  // An ID outside the register range (0xF = RNONE) never writes.
  assign w_we_e = (int'(dstE) < NREG);
  assign w_we_m = (int'(dstM) < NREG);
  assign w_read = in_valid && !stall;

  always_comb begin
    w_src_a = RNONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: w_src_a = rA;
      4'h9, 4'hB:             w_src_a = RSP_ID;
      default:                w_src_a = RNONE;
    endcase
  end

  always_comb begin
    w_src_b = RNONE;
    case (icode)
      4'h4, 4'h5, 4'h6:       w_src_b = rB;
      4'h8, 4'h9, 4'hA, 4'hB: w_src_b = RSP_ID;
      default:                w_src_b = RNONE;
    endcase
  end

  // Bypass order mirrors the write priority: valM beats valE when both
  // target the same register, so a read sees what the file will hold.
  always_comb begin
    w_rd_a = '0;
    if (int'(w_src_a) >= NREG)      w_rd_a = '0;
    else if (w_we_m && w_src_a == dstM) w_rd_a = valM;
    else if (w_we_e && w_src_a == dstE) w_rd_a = valE;
    else                            w_rd_a = r_regs[w_src_a];
  end

  always_comb begin
    w_rd_b = '0;
    if (int'(w_src_b) >= NREG)      w_rd_b = '0;
    else if (w_we_m && w_src_b == dstM) w_rd_b = valM;
    else if (w_we_e && w_src_b == dstE) w_rd_b = valE;
    else                            w_rd_b = r_regs[w_src_b];
  end

  // M is written after E so it wins on a shared destination (popq %rsp).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_we_e) r_regs[dstE] <= valE;
      if (w_we_m) r_regs[dstM] <= valM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_a     <= RNONE;
      r_src_b     <= RNONE;
      r_val_a     <= '0;
      r_val_b     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_read) begin
      r_src_a     <= w_src_a;
      r_src_b     <= w_src_b;
      r_val_a     <= w_rd_a;
      r_val_b     <= w_rd_b;
      r_out_valid <= 1'b1;
    end else if (!stall) begin
      r_out_valid <= 1'b0;
    end
  end

  assign srcA      = r_src_a;
  assign srcB      = r_src_b;
  assign valA      = r_val_a;
  assign valB      = r_val_b;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_decode_regfile.sv
module tb_decode_regfile;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, stall;
  logic [3:0]   icode, rA, rB, dstE, dstM;
  logic [W-1:0] valE, valM;
  logic [3:0]   srcA, srcB;
  logic [W-1:0] valA, valB;
  logic         out_valid;

  always #5 clk = ~clk;

  decode_regfile #(.WIDTH(W), .NREG(15), .RSP_ID(4'd4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .icode(icode), .rA(rA), .rB(rB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .out_valid(out_valid)
  );

  // Reference state: architectural registers plus the expected outputs.
  logic [W-1:0] m_regs [15];
  logic [3:0]   e_srca, e_srcb;
  logic [W-1:0] e_vala, e_valb;
  logic         e_ov;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [3:0] ref_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  // Value a read of register s returns on this edge: the register as it
  // will be right after the edge's writes (M applied last).
  function automatic logic [W-1:0] ref_read(input logic [3:0] s);
    logic [W-1:0] v;
    if (s == 4'hF) return '0;
    v = m_regs[s];
    if (dstE == s) v = valE;
    if (dstM == s) v = valM;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    e_srca = 4'hF; e_srcb = 4'hF; e_vala = '0; e_valb = '0; e_ov = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"}, W'(out_valid), W'(e_ov));
    chk({tag, ".srcA"}, W'(srcA), W'(e_srca));
    chk({tag, ".srcB"}, W'(srcB), W'(e_srcb));
    chk({tag, ".valA"}, valA, e_vala);
    chk({tag, ".valB"}, valB, e_valb);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check #1 after.
  task automatic cyc(input string tag, input logic iv, input logic st,
                     input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [3:0] de, input logic [W-1:0] ve,
                     input logic [3:0] dm, input logic [W-1:0] vm);
    logic [3:0] sa, sb;
    logic [W-1:0] na, nb;
    in_valid = iv; stall = st; icode = ic; rA = ra; rB = rb;
    dstE = de; valE = ve; dstM = dm; valM = vm;
    sa = ref_src_a(ic, ra);
    sb = ref_src_b(ic, rb);
    na = ref_read(sa);
    nb = ref_read(sb);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (iv && !st) begin
        e_srca = sa; e_srcb = sb; e_vala = na; e_valb = nb; e_ov = 1'b1;
      end else if (!st) begin
        e_ov = 1'b0;
      end
      if (de != 4'hF) m_regs[de] = ve;
      if (dm != 4'hF) m_regs[dm] = vm;
    end
    #1;
    chk_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, '0, 4'hF, '0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; stall = 0; icode = 0; rA = 4'hF; rB = 4'hF;
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    model_reset();
    @(negedge clk);
    // Write attempted while reset is held must be discarded.
    cyc("rst_hold", 1'b1, 1'b0, 4'h6, 4'h3, 4'h3, 4'h3, 64'hBAD, 4'h2, 64'hBAD2);
    rst = 1'b0;
    idle("rst_idle");

    cyc("rst_read", 1'b1, 1'b0, 4'h6, 4'h0, 4'h3, 4'hF, '0, 4'hF, '0);

    // Write then read.
    cyc("wr_e3", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h3, 64'h1234, 4'hF, '0);
    cyc("rd_33", 1'b1, 1'b0, 4'h6, 4'h3, 4'h3, 4'hF, '0, 4'hF, '0);
    chk("plan.rd_33.valA", valA, 64'h1234);

    // Bypass on the same edge.
    cyc("pre_r1", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h10, 4'hF, '0);
    cyc("bypass", 1'b1, 1'b0, 4'h4, 4'h2, 4'h1, 4'hF, '0, 4'h2, 64'hDEAD);
    chk("plan.bypass.valA", valA, 64'hDEAD);
    chk("plan.bypass.valB", valB, 64'h10);

    // dstE == dstM: M wins, with a concurrent popq.
    cyc("popq", 1'b1, 1'b0, 4'hB, 4'h4, 4'hF, 4'h4, 64'h100, 4'h4, 64'h200);
    cyc("popq_rd", 1'b1, 1'b0, 4'h6, 4'h4, 4'h4, 4'hF, '0, 4'hF, '0);
    chk("plan.popq_rd.valA", valA, 64'h200);

    // Stack ops.
    cyc("wr_rsp", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h4, 64'h800, 4'hF, '0);
    cyc("call", 1'b1, 1'b0, 4'h8, 4'h1, 4'h1, 4'hF, '0, 4'hF, '0);
    chk("plan.call.valB", valB, 64'h800);
    cyc("ret", 1'b1, 1'b0, 4'h9, 4'hF, 4'hF, 4'hF, '0, 4'hF, '0);
    idle("after_ret");

    // Stall with requests and writes to reg5.
    cyc("stall0", 1'b1, 1'b1, 4'h6, 4'h5, 4'h5, 4'h5, 64'hA1, 4'hF, '0);
    cyc("stall1", 1'b1, 1'b1, 4'h6, 4'h5, 4'h5, 4'h5, 64'hA2, 4'hF, '0);
    cyc("stall2", 1'b1, 1'b1, 4'h6, 4'h5, 4'h5, 4'hF, '0, 4'h5, 64'hA3);
    cyc("unstall", 1'b1, 1'b0, 4'h2, 4'h5, 4'h0, 4'hF, '0, 4'hF, '0);
    chk("plan.unstall.valA", valA, 64'hA3);

    // Stall while out_valid is high holds it high.
    cyc("stall_hold", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, '0, 4'hF, '0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] de, dm;
      de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) dm = de;
      cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
          4'($urandom), 4'($urandom), 4'($urandom),
          de, {$urandom, $urandom}, dm, {$urandom, $urandom});
    end

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    cyc("pre_async", 1'b1, 1'b0, 4'hA, 4'h3, 4'h0, 4'h3, 64'h77, 4'hF, '0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc("post_async", 1'b1, 1'b0, 4'h6, 4'h3, 4'h1, 4'hF, '0, 4'hF, '0);
    chk("post_async.valA_zero", valA, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
